// File: rtl/puf_request_arbiter.sv
// puf_request_arbiter
// Shares one ring-oscillator PUF wrapper between N_REQ requesters. A
// round-robin pick grants one owner, latches its challenge, clears the
// wrapper's response handler, lets the oscillators settle with enable low,
// runs the wrapper until it reports valid or a timeout expires, and returns
// the response to the owner as a one-cycle pulse.
module puf_request_arbiter #(
    parameter int N_REQ          = 2,
    parameter int SETTLE_CYCLES  = 4,
    parameter int TIMEOUT_CYCLES = 50000
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [N_REQ-1:0]     req,
    input  logic [8*N_REQ-1:0]   req_challenge,
    output logic [N_REQ-1:0]     grant,
    output logic [N_REQ-1:0]     rsp_valid,
    output logic [7:0]           rsp_data,
    output logic                 rsp_timeout,
    output logic                 busy,
    output logic [7:0]           puf_challenge,
    output logic                 puf_enable,
    output logic                 puf_reset,
    input  logic [7:0]           puf_response,
    input  logic                 puf_valid
);

    localparam int PTR_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    localparam int SET_W = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
    localparam int RUN_W = $clog2(TIMEOUT_CYCLES + 1);

    localparam logic [PTR_W-1:0] PTR_LAST    = PTR_W'(N_REQ - 1);
    localparam logic [SET_W-1:0] SETTLE_LAST = SET_W'(SETTLE_CYCLES - 1);
    localparam logic [RUN_W-1:0] RUN_LAST    = RUN_W'(TIMEOUT_CYCLES - 1);
    localparam logic [N_REQ-1:0] ONE_HOT_0   = {{(N_REQ-1){1'b0}}, 1'b1};

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_CLEAR  = 3'd1;
    localparam logic [2:0] S_SETTLE = 3'd2;
    localparam logic [2:0] S_RUN    = 3'd3;
    localparam logic [2:0] S_DONE   = 3'd4;

    // Round-robin search: first set request strictly after ptr, wrapping.
    // Scanning from the farthest candidate down lets the nearest one win.
    // Result is {found, index}.
    function automatic logic [PTR_W:0] rr_pick(
        input logic [N_REQ-1:0] r,
        input logic [PTR_W-1:0] ptr
    );
        logic [PTR_W:0] res;
        int             idx;
        res = '0;
        for (int i = N_REQ; i >= 1; i--) begin
            idx = (int'(ptr) + i) % N_REQ;
            if (r[PTR_W'(idx)]) begin
                res = {1'b1, PTR_W'(idx)};
            end
        end
        return res;
    endfunction

    logic [2:0]       state_q, state_d;
    logic [PTR_W-1:0] rr_ptr_q, rr_ptr_d;
    logic [SET_W-1:0] settle_cnt_q, settle_cnt_d;
    logic [RUN_W-1:0] run_cnt_q, run_cnt_d;
    logic [N_REQ-1:0] grant_q, grant_d;
    logic [N_REQ-1:0] rsp_valid_q, rsp_valid_d;
    logic [7:0]       rsp_data_q, rsp_data_d;
    logic             rsp_timeout_q, rsp_timeout_d;
    logic             busy_q, busy_d;
    logic [7:0]       puf_challenge_q, puf_challenge_d;
    logic             puf_enable_q, puf_enable_d;
    logic             puf_reset_q, puf_reset_d;

    logic [PTR_W:0]   pick_s;
    logic             pick_found_s;
    logic [PTR_W-1:0] pick_idx_s;

    assign pick_s       = rr_pick(req, rr_ptr_q);
    assign pick_found_s = pick_s[PTR_W];
    assign pick_idx_s   = pick_s[PTR_W-1:0];

    // Next-state and next-output logic for the transaction sequencer.
    always_comb begin
        state_d         = state_q;
        rr_ptr_d        = rr_ptr_q;
        settle_cnt_d    = settle_cnt_q;
        run_cnt_d       = run_cnt_q;
        grant_d         = grant_q;
        rsp_valid_d     = '0;
        rsp_data_d      = rsp_data_q;
        rsp_timeout_d   = rsp_timeout_q;
        busy_d          = busy_q;
        puf_challenge_d = puf_challenge_q;
        puf_enable_d    = puf_enable_q;
        puf_reset_d     = puf_reset_q;

        case (state_q)
            S_IDLE: begin
                if (pick_found_s) begin
                    grant_d         = ONE_HOT_0 << pick_idx_s;
                    puf_challenge_d = req_challenge[{pick_idx_s, 3'b000} +: 8];
                    rr_ptr_d        = pick_idx_s;
                    puf_reset_d     = 1'b1;
                    busy_d          = 1'b1;
                    state_d         = S_CLEAR;
                end else begin
                    state_d = S_IDLE;
                end
            end

            S_CLEAR: begin
                puf_reset_d  = 1'b0;
                settle_cnt_d = '0;
                state_d      = S_SETTLE;
            end

            S_SETTLE: begin
                if (settle_cnt_q == SETTLE_LAST) begin
                    puf_enable_d = 1'b1;
                    run_cnt_d    = '0;
                    state_d      = S_RUN;
                end else begin
                    settle_cnt_d = settle_cnt_q + SET_W'(1);
                end
            end

            S_RUN: begin
                // A response on the final allowed cycle still counts as a
                // response, so the valid check comes before the timeout.
                if (puf_valid) begin
                    rsp_data_d    = puf_response;
                    rsp_timeout_d = 1'b0;
                    rsp_valid_d   = grant_q;
                    puf_enable_d  = 1'b0;
                    state_d       = S_DONE;
                end else if (run_cnt_q == RUN_LAST) begin
                    rsp_data_d    = 8'h00;
                    rsp_timeout_d = 1'b1;
                    rsp_valid_d   = grant_q;
                    puf_enable_d  = 1'b0;
                    state_d       = S_DONE;
                end else begin
                    run_cnt_d = run_cnt_q + RUN_W'(1);
                end
            end

            S_DONE: begin
                grant_d = '0;
                busy_d  = 1'b0;
                state_d = S_IDLE;
            end

            default: begin
                grant_d      = '0;
                busy_d       = 1'b0;
                puf_enable_d = 1'b0;
                puf_reset_d  = 1'b0;
                state_d      = S_IDLE;
            end
        endcase
    end

    // State and output registers; reset drops the wrapper enable at once.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q         <= S_IDLE;
            rr_ptr_q        <= PTR_LAST;
            settle_cnt_q    <= '0;
            run_cnt_q       <= '0;
            grant_q         <= '0;
            rsp_valid_q     <= '0;
            rsp_data_q      <= 8'h00;
            rsp_timeout_q   <= 1'b0;
            busy_q          <= 1'b0;
            puf_challenge_q <= 8'h00;
            puf_enable_q    <= 1'b0;
            puf_reset_q     <= 1'b0;
        end else begin
            state_q         <= state_d;
            rr_ptr_q        <= rr_ptr_d;
            settle_cnt_q    <= settle_cnt_d;
            run_cnt_q       <= run_cnt_d;
            grant_q         <= grant_d;
            rsp_valid_q     <= rsp_valid_d;
            rsp_data_q      <= rsp_data_d;
            rsp_timeout_q   <= rsp_timeout_d;
            busy_q          <= busy_d;
            puf_challenge_q <= puf_challenge_d;
            puf_enable_q    <= puf_enable_d;
            puf_reset_q     <= puf_reset_d;
        end
    end

    assign grant         = grant_q;
    assign rsp_valid     = rsp_valid_q;
    assign rsp_data      = rsp_data_q;
    assign rsp_timeout   = rsp_timeout_q;
    assign busy          = busy_q;
    assign puf_challenge = puf_challenge_q;
    assign puf_enable    = puf_enable_q;
    assign puf_reset     = puf_reset_q;

endmodule

// File: doc/puf_request_arbiter.md
Name: puf_request_arbiter

Overview:
- Shares one 9-RO PUF wrapper (8-bit challenge, enable, active-high handler reset, 8-bit response, valid) between N_REQ requesters, e.g. key-generation and authentication.
- Round-robin arbitration, challenge latch, handler clear, RO settle delay, enable/valid sequencing, timeout, and response return to the granted requester.
- Sits between the system-side requesters and the PUF wrapper. It is the only driver of the wrapper's challenge, enable and reset inputs.

Parameters:
N_REQ, 2, number of requesters (2..8)
SETTLE_CYCLES, 4, cycles challenge is held stable with enable low before a run (>=1)
TIMEOUT_CYCLES, 50000, max RUN cycles waiting for puf_valid; counter width $clog2(TIMEOUT_CYCLES+1)

Ports:
clk  input  1  system clock; all state changes on rising edge
reset  input  1  asynchronous, active-low reset
req  input  N_REQ  per-requester request level
req_challenge  input  8*N_REQ  challenge of requester i at [8i+7:8i]
grant  output  N_REQ  one-hot owner of the PUF; all-zero when idle
rsp_valid  output  N_REQ  one-cycle pulse to owner: rsp_data/rsp_timeout valid
rsp_data  output  8  captured response; 0 on timeout
rsp_timeout  output  1  qualifies rsp_valid: run ended without puf_valid
busy  output  1  high whenever state != IDLE
puf_challenge  output  8  challenge to wrapper; held through whole transaction
puf_enable  output  1  wrapper enable
puf_reset  output  1  active-high clear of the wrapper's response handler
puf_response  input  8  wrapper response
puf_valid  input  1  wrapper response-valid

Behaviour:
- All outputs registered. During reset: state IDLE, grant 0, rsp_valid 0, rsp_data 0, rsp_timeout 0, busy 0, puf_challenge 0, puf_enable 0, puf_reset 0, counters 0, rr pointer = N_REQ-1 so requester 0 wins first.
- States: IDLE, CLEAR, SETTLE, RUN, DONE.
- IDLE: if any req bit is high at an edge, pick the first set bit searching upward from rr_ptr+1 (wrap modulo N_REQ).
  - On that edge: grant[g]=1, puf_challenge=req_challenge[g], rr_ptr=g, puf_reset=1, busy=1, state CLEAR.
- CLEAR: lasts exactly 1 cycle. Next edge: puf_reset=0, settle counter=0, state SETTLE.
- SETTLE: puf_enable=0 for exactly SETTLE_CYCLES cycles. On the last one: puf_enable=1, run counter=0, state RUN.
- RUN: puf_enable=1; run counter increments each cycle.
  - Edge with puf_valid=1: rsp_data=puf_response, rsp_timeout=0, rsp_valid[g]=1, puf_enable=0, state DONE.
  - Else, if the counter reaches TIMEOUT_CYCLES-1: rsp_data=0, rsp_timeout=1, rsp_valid[g]=1, puf_enable=0, state DONE.
  - puf_valid and timeout on the same edge: valid wins.
- DONE: lasts 1 cycle; rsp_valid high for exactly this cycle; grant still held. Next edge: rsp_valid=0, grant=0, busy=0, state IDLE.
  - rsp_data and rsp_timeout hold until the next capture.
- Earliest next grant: edge after the first IDLE cycle, so back-to-back transactions have a 1-cycle IDLE gap.
- Latency, valid asserted in RUN cycle k (k>=1): grant edge to rsp_valid = 1 + SETTLE_CYCLES + k cycles.
- puf_valid outside RUN is ignored.
- req_challenge is sampled only at grant. Later changes, and req dropping mid-transaction, do not abort; the response is still pulsed to the owner.
- Requester protocol: hold req until its rsp_valid pulse, then drop it or keep it high to re-request.
  - A re-request is granted only after every other pending requester under round-robin.
- Single requester continuously requesting is re-granted every transaction.
- Async reset mid-transaction: immediate return to reset values. puf_enable drops without waiting for the clock; no rsp_valid is issued.
- puf_challenge stays constant from the CLEAR cycle through DONE, never changing while puf_enable=1.

Test Plan:
- Reset release, req=01, challenge0=8'hA5, SETTLE=4, puf_valid in RUN cycle 3 with response 8'h3C -> grant=01, puf_challenge=A5, puf_reset high 1 cycle, enable low 4 cycles then high, rsp_valid=01 one cycle with rsp_data=3C and rsp_timeout=0; grant edge to pulse = 8 cycles.
- req=11 held continuously, each run answered -> grants alternate 01,10,01,10 starting with 01, with a 1-cycle IDLE gap between transactions.
- TIMEOUT_CYCLES=16, puf_valid never asserted -> enable high exactly 16 cycles, rsp_valid pulse with rsp_timeout=1 and rsp_data=00, then IDLE.
- During RUN: change req_challenge[g] to 8'hFF, drop req, inject puf_valid pulses in SETTLE -> puf_challenge unchanged, SETTLE pulse ignored, transaction completes and rsp_valid still pulses.
- puf_valid asserted on the timeout cycle -> rsp_timeout=0 and the response is captured.
- Async reset asserted in RUN mid-cycle -> puf_enable, grant and busy go 0 immediately; no rsp_valid; after release requester 0 is served first.
